// File: rtl/round_robin_ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority pointer, registered one-hot
// grants, an optional hold limit and a one-cycle turnaround gap after every tenure.
module round_robin_ring_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         grant,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic [N-1:0]         ptr,
    output logic                 timeout
);

    localparam int unsigned OW = $clog2(N);
    localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            busy_q, busy_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [N-1:0]    ptr_q, ptr_d;
    logic            timeout_q, timeout_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic [OW-1:0]   ptr_idx;
    logic [OW-1:0]   cand;
    logic [OW-1:0]   win_idx;
    logic            win_found;
    logic [N-1:0]    win_onehot;

    logic            rel_done;
    logic            rel_drop;
    logic            rel_limit;
    logic            release_now;

    // Winner search: first set req bit starting at the pointer slot, wrapping N-1 -> 0.
    always_comb begin
        ptr_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ptr_q[i]) begin
                ptr_idx = OW'(i);
            end
        end

        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = OW'((32'(ptr_idx) + k) % N);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        win_onehot          = '0;
        win_onehot[win_idx] = win_found;
    end

    always_comb begin
        rel_done    = done[owner_q];
        rel_drop    = ~req[owner_q];
        rel_limit   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
        release_now = rel_done | rel_drop | rel_limit;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE, GAP: begin
                grant_d = '0;
                state_d = IDLE;
                if (win_found) begin
                    state_d = GRANT;
                    grant_d = win_onehot;
                    owner_d = win_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    ptr_d     = {grant_q[N-2:0], grant_q[N-1]};
                    // A voluntary release on the same edge as the limit is not a timeout.
                    timeout_d = rel_limit & ~rel_done & ~rel_drop;
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = |grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            ptr_q     <= {{(N-1){1'b0}}, 1'b1};
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign ptr     = ptr_q;
    assign timeout = timeout_q;

endmodule
